// File: rtl/sdram_pkg.sv
// Shared widths, queue FSM states and the FIFO entry layout for the SDRAM request path.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 24;
    localparam int SDRAM_DATA_W = 16;
    localparam int SDRAM_MASK_W = SDRAM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sdram_state_t;

    // wr is forced to 0 for reads so a stored entry is never both
    typedef struct packed {
        logic                    rd;
        logic [SDRAM_MASK_W-1:0] wr;
        logic [SDRAM_ADDR_W-1:0] addr;
        logic [SDRAM_DATA_W-1:0] wdata;
    } sdram_entry_t;

endpackage

// File: rtl/sdram_core_if.sv
// Manager/subordinate handshake between a request queue and one SDRAM arbiter port.
interface sdram_core_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int MASK_W = DATA_W / 8
);
    logic              rd;
    logic [MASK_W-1:0] wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              accept;
    logic              ack;
    logic              error;
    logic [DATA_W-1:0] read_data;

    modport man (
        output rd, wr, addr, write_data,
        input  accept, ack, error, read_data
    );

    modport sub (
        input  rd, wr, addr, write_data,
        output accept, ack, error, read_data
    );
endinterface

// File: rtl/sdram_sync_fifo.sv
// Generic DEPTH-entry register FIFO with a combinational head; DEPTH must be a power of two.
module sdram_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [WIDTH-1:0] entry_rd [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = entry_rd[rd_ptr_q];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_q;
            always_ff @(posedge clk) begin
                if (srst) begin
                    entry_q <= '0;
                end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_q <= push_data_i;
                end
            end
            assign entry_rd[gi] = entry_q;
        end
    endgenerate

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sdram_req_queue.sv
// Client request queue driving one SDRAM arbiter port, one transaction in flight at a time.
// Optional watchdog enabled by defining SDRAM_REQ_TIMEOUT_EN.
module sdram_req_queue
    import sdram_pkg::*;
#(
    parameter int ADDR_W  = SDRAM_ADDR_W,
    parameter int DATA_W  = SDRAM_DATA_W,
    parameter int MASK_W  = DATA_W / 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rd,
    input  logic [MASK_W-1:0] req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_rd,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    sdram_core_if.man         core_if
);
    localparam int ENTRY_W = $bits(sdram_entry_t);

    sdram_state_t         state_q, state_d;
    sdram_entry_t         push_entry, head_entry;
    logic [ENTRY_W-1:0]   head_bits;
    logic                 fifo_full, fifo_empty, push, issuing, timeout_hit;
    logic [$clog2(DEPTH):0] fifo_level_unused;
    logic                 complete, fail;
    logic [DATA_W-1:0]    rdata_cap;
    logic                 rsp_valid_q, rsp_rd_q, rsp_err_q;
    logic [DATA_W-1:0]    rsp_rdata_q;

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready && (req_rd || (|req_wr));

    always_comb begin
        push_entry.rd    = req_rd;
        push_entry.wr    = req_rd ? '0 : req_wr;
        push_entry.addr  = req_addr;
        push_entry.wdata = req_rd ? '0 : req_wdata;
    end

    sdram_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .srst        (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (complete),
        .head_o      (head_bits),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_level_unused)
    );

    assign head_entry = sdram_entry_t'(head_bits);

    assign issuing            = (state_q == ISSUE);
    assign core_if.rd         = issuing && head_entry.rd;
    assign core_if.wr         = issuing ? head_entry.wr    : '0;
    assign core_if.addr       = issuing ? head_entry.addr  : '0;
    assign core_if.write_data = issuing ? head_entry.wdata : '0;

`ifdef SDRAM_REQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // held at zero in IDLE, so the count restarts on every entry to ISSUE
    assign to_cnt_d    = (state_q == IDLE) ? '0 : to_cnt_q + 1'b1;
    assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        complete  = 1'b0;
        fail      = 1'b0;
        rdata_cap = '0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = ISSUE;
            end
            ISSUE: begin
                if (core_if.error) begin
                    complete = 1'b1;
                    fail     = 1'b1;
                end else if (core_if.accept && core_if.ack) begin
                    complete  = 1'b1;
                    rdata_cap = head_entry.rd ? core_if.read_data : '0;
                end else if (timeout_hit) begin
                    complete = 1'b1;
                    fail     = 1'b1;
                end else if (core_if.accept) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_if.error || (timeout_hit && !core_if.ack)) begin
                    complete = 1'b1;
                    fail     = 1'b1;
                end else if (core_if.ack) begin
                    complete  = 1'b1;
                    rdata_cap = head_entry.rd ? core_if.read_data : '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (complete) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= complete;
            rsp_rd_q    <= complete && head_entry.rd;
            rsp_err_q   <= fail;
            rsp_rdata_q <= rdata_cap;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue; the timeout scenario runs only with SDRAM_REQ_TIMEOUT_EN.
module tb_sdram_req_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_rd;
    logic [1:0]  req_wr;
    logic [23:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_rd, rsp_err;
    logic [15:0] rsp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    sdram_core_if #(.ADDR_W(24), .DATA_W(16)) core_bus ();

    sdram_req_queue #(
        .ADDR_W  (24),
        .DATA_W  (16),
        .MASK_W  (2),
        .DEPTH   (4),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rd    (rsp_rd),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .core_if   (core_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic rd, input logic [1:0] wr,
                            input logic [23:0] a, input logic [15:0] d);
        req_valid = 1'b1;
        req_rd    = rd;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 2'b00;
    endtask

    task automatic set_core(input logic acc, input logic ak, input logic er, input logic [15:0] rdat);
        core_bus.accept    = acc;
        core_bus.ack       = ak;
        core_bus.error     = er;
        core_bus.read_data = rdat;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_rd = 1'b0; req_wr = 2'b00; req_addr = '0; req_wdata = '0;
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rd", rsp_rd, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_core_rd", core_bus.rd, 0);
        check("rst_core_wr", core_bus.wr, 0);
        check("rst_core_addr", core_bus.addr, 0);
        check("rst_core_wdata", core_bus.write_data, 0);

        // single read, accepted late, acked three cycles later
        push_req(1'b1, 2'b00, 24'h000123, 16'h0000);
        check("t1_idle_rd", core_bus.rd, 0);
        tick();
        check("t1_issue_rd", core_bus.rd, 1);
        check("t1_issue_addr", core_bus.addr, 32'h123);
        check("t1_issue_wr", core_bus.wr, 0);
        tick();
        check("t1_hold_rd", core_bus.rd, 1);
        check("t1_hold_addr", core_bus.addr, 32'h123);
        set_core(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        check("t1_wait_rd", core_bus.rd, 0);
        check("t1_wait_addr", core_bus.addr, 0);
        tick();
        tick();
        set_core(1'b0, 1'b1, 1'b0, 16'hBEEF);
        check("t1_pre_rsp", rsp_valid, 0);
        tick();
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_rd", rsp_rd, 1);
        check("t1_rsp_rdata", rsp_rdata, 32'hBEEF);
        check("t1_rsp_err", rsp_err, 0);
        $display("txn read addr=0x000123 rsp_rdata=0x%04h err=%0d", rsp_rdata, rsp_err);
        tick();
        check("t1_rsp_pulse", rsp_valid, 0);
        check("t1_rdata_clr", rsp_rdata, 0);

        // fill with writes while the core withholds accept
        for (int i = 0; i < 4; i++) push_req(1'b0, 2'b11, 24'(32'h200 + i), 16'(32'hA000 + i));
        check("t2_full_ready", req_ready, 0);
        check("t2_head_wr", core_bus.wr, 3);
        check("t2_head_addr", core_bus.addr, 32'h200);
        check("t2_head_wdata", core_bus.write_data, 32'hA000);
        req_valid = 1'b1; req_rd = 1'b0; req_wr = 2'b11; req_addr = 24'h204; req_wdata = 16'hA004;
        tick();
        tick();
        check("t2_still_full", req_ready, 0);
        check("t2_stable_addr", core_bus.addr, 32'h200);
        check("t2_stable_wdata", core_bus.write_data, 32'hA000);
        set_core(1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        check("t2_c0_valid", rsp_valid, 1);
        check("t2_c0_rd", rsp_rd, 0);
        check("t2_c0_err", rsp_err, 0);
        check("t2_c0_rdata", rsp_rdata, 0);
        check("t2_c0_idle_wr", core_bus.wr, 0);
        check("t2_c0_ready", req_ready, 1);
        $display("txn write addr=0x000200 err=%0d", rsp_err);
        tick();
        req_valid = 1'b0; req_wr = 2'b00;
        check("t2_fifth_taken", req_ready, 0);
        check("t2_c0_pulse", rsp_valid, 0);
        for (int k = 1; k < 5; k++) begin
            check($sformatf("t2_w%0d_wr", k), core_bus.wr, 3);
            check($sformatf("t2_w%0d_addr", k), core_bus.addr, 32'h200 + k);
            check($sformatf("t2_w%0d_wdata", k), core_bus.write_data, 32'hA000 + k);
            set_core(1'b1, 1'b1, 1'b0, 16'h0000);
            tick();
            set_core(1'b0, 1'b0, 1'b0, 16'h0000);
            check($sformatf("t2_w%0d_rsp", k), rsp_valid, 1);
            $display("txn write addr=0x%06h err=%0d", 24'(32'h200 + k), rsp_err);
            tick();
        end
        check("t2_drained_wr", core_bus.wr, 0);
        check("t2_drained_ready", req_ready, 1);

        // error instead of accept, then a read with a stray write mask
        push_req(1'b0, 2'b11, 24'h000300, 16'h1111);
        push_req(1'b1, 2'b01, 24'h000301, 16'h2222);
        check("t3_issue_wr", core_bus.wr, 3);
        check("t3_issue_addr", core_bus.addr, 32'h300);
        set_core(1'b0, 1'b0, 1'b1, 16'h5555);
        tick();
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        check("t3_err_valid", rsp_valid, 1);
        check("t3_err_err", rsp_err, 1);
        check("t3_err_rdata", rsp_rdata, 0);
        check("t3_err_rd", rsp_rd, 0);
        $display("txn write addr=0x000300 err=%0d", rsp_err);
        tick();
        check("t3_rd_rd", core_bus.rd, 1);
        check("t3_rd_wr", core_bus.wr, 0);
        check("t3_rd_addr", core_bus.addr, 32'h301);
        check("t3_rd_wdata", core_bus.write_data, 0);
        set_core(1'b1, 1'b1, 1'b0, 16'h1234);
        tick();
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        check("t3_rd_valid", rsp_valid, 1);
        check("t3_rd_rsp_rd", rsp_rd, 1);
        check("t3_rd_err", rsp_err, 0);
        check("t3_rd_rdata", rsp_rdata, 32'h1234);
        $display("txn read addr=0x000301 rsp_rdata=0x%04h err=%0d", rsp_rdata, rsp_err);
        tick();

        // request with neither rd nor wr is dropped; core strobes in IDLE are ignored
        push_req(1'b0, 2'b00, 24'h000555, 16'h0000);
        tick();
        check("t3_null_rd", core_bus.rd, 0);
        check("t3_null_wr", core_bus.wr, 0);
        set_core(1'b1, 1'b1, 1'b1, 16'h9999);
        tick();
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        check("t3_idle_ignored", rsp_valid, 0);

        // ack and error together in WAIT count as an error
        push_req(1'b1, 2'b00, 24'h000400, 16'h0000);
        tick();
        set_core(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        set_core(1'b0, 1'b1, 1'b1, 16'h7777);
        tick();
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        check("t3_ackerr_valid", rsp_valid, 1);
        check("t3_ackerr_err", rsp_err, 1);
        check("t3_ackerr_rdata", rsp_rdata, 0);
        check("t3_ackerr_rd", rsp_rd, 1);
        $display("txn read addr=0x000400 err=%0d", rsp_err);
        tick();

        // reset in WAIT with two more entries queued
        for (int i = 0; i < 3; i++) push_req(1'b1, 2'b00, 24'(32'h500 + i), 16'h0000);
        check("t4_issue_addr", core_bus.addr, 32'h500);
        set_core(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        check("t4_wait_rd", core_bus.rd, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_rst_rsp", rsp_valid, 0);
        check("t4_rst_rd", core_bus.rd, 0);
        check("t4_rst_ready", req_ready, 1);
        set_core(1'b0, 1'b1, 1'b0, 16'hAAAA);
        tick();
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_quiet_rd%0d", i), core_bus.rd, 0);
            check($sformatf("t4_quiet_rsp%0d", i), rsp_valid, 0);
            tick();
        end
        $display("txn reset flush done");

`ifdef SDRAM_REQ_TIMEOUT_EN
        // accepted but never acked: error eight cycles after ISSUE entry
        push_req(1'b1, 2'b00, 24'h000600, 16'h0000);
        push_req(1'b1, 2'b00, 24'h000601, 16'h0000);
        check("t5_issue_rd", core_bus.rd, 1);
        set_core(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (6) tick();
        check("t5_not_yet", rsp_valid, 0);
        tick();
        check("t5_to_valid", rsp_valid, 1);
        check("t5_to_err", rsp_err, 1);
        check("t5_to_rd", rsp_rd, 1);
        check("t5_to_rdata", rsp_rdata, 0);
        check("t5_to_core_rd", core_bus.rd, 0);
        $display("txn read addr=0x000600 timeout err=%0d", rsp_err);
        tick();
        check("t5_next_rd", core_bus.rd, 1);
        check("t5_next_addr", core_bus.addr, 32'h601);
        set_core(1'b1, 1'b1, 1'b0, 16'h4321);
        tick();
        set_core(1'b0, 1'b0, 1'b0, 16'h0000);
        check("t5_next_rdata", rsp_rdata, 32'h4321);
        check("t5_next_err", rsp_err, 0);
        $display("txn read addr=0x000601 rsp_rdata=0x%04h err=%0d", rsp_rdata, rsp_err);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_req_queue.md
Name: sdram_req_queue

Overview:
Per-client request buffer sitting directly upstream of the SDRAM two-port arbiter; drives one arbiter port (sdram_core_if manager side).
Accepts read/write requests from a client over valid/ready and queues them in a DEPTH-entry FIFO.
Issues one transaction at a time and holds it stable until the core accepts it, then waits for ack/error.
Returns a single-cycle completion (with read data for reads) to the client.

Parameters:
ADDR_W, 24, SDRAM word address width; must match sdram_core_if.
DATA_W, 16, data width; must match sdram_core_if.
MASK_W, DATA_W/8, byte-write mask width (sdram_core_if wr field).
DEPTH, 4, FIFO entries; power of two, >=2.
TIMEOUT, 255, watchdog limit in cycles; used only with SDRAM_REQ_TIMEOUT_EN.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  client request present
req_ready  out  1  queue can take a request (= not full)
req_rd  in  1  read request
req_wr  in  MASK_W  byte-write mask; nonzero = write
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse; no backpressure
rsp_rd  out  1  completion was a read
rsp_err  out  1  transaction ended in error (or timeout)
rsp_rdata  out  DATA_W  read data, valid with rsp_valid & rsp_rd; 0 otherwise
core_if  sdram_core_if.man  -  toward arbiter port: rd, wr, addr, write_data out; accept, ack, error, read_data in

Behaviour:
- Clock clk, reset rst: one clock; reset is synchronous, active-high.
- Reset values: FIFO empty, state IDLE, req_ready=1, rsp_valid=0, rsp_rd=0, rsp_err=0, rsp_rdata=0, core_if.rd=0, core_if.wr=0, core_if.addr=0, core_if.write_data=0.
- Push: on req_valid & req_ready, if req_rd=1 or req_wr!=0. If both are set, read wins and the mask is stored as 0. If neither is set, nothing is stored.
- req_ready = !full. When full, req_ready stays 0 even in the cycle a pop occurs.
- FSM IDLE: if FIFO non-empty, go to ISSUE at next edge. Latency: a push at edge t into an empty queue gives core_if.rd/wr asserted in the cycle after edge t+1.
- FSM ISSUE: drive core_if.rd/wr/addr/write_data from the FIFO head, held stable until resolved.
  - accept & ack in the same cycle: complete.
  - accept alone: go to WAIT.
  - error (with or without accept): complete with err=1.
- FSM WAIT: core_if.rd/wr/addr/write_data all 0.
  - ack: complete.
  - error: complete with err=1.
  - ack & error together: treated as error.
- Complete (registered): next cycle rsp_valid=1, rsp_rd=head.rd, rsp_err as above, rsp_rdata=core_if.read_data captured at the ack edge (0 for writes or errors). Pop the head at the same edge; state returns to IDLE.
- Back-to-back: next issue occurs no earlier than one IDLE cycle after completion, so at most 1 outstanding transaction.
- In IDLE and WAIT, core_if.rd=0 and core_if.wr=0 always. Outputs are never X: unused fields are driven 0.
- Push and pop may occur on the same edge; count is unchanged and pointers wrap modulo DEPTH.
- accept/ack/error arriving in IDLE are ignored.
- Reset mid-transaction: queue flushed, the in-flight transaction is abandoned with no rsp, and core signals are 0 from the next cycle. The arbiter shares rst.

Optional Feature:
SDRAM_REQ_TIMEOUT_EN
- Defined: a counter runs in ISSUE and WAIT and clears on entry to ISSUE. Reaching TIMEOUT cycles without resolution completes the transaction with rsp_err=1, pops it, and drops core_if.rd/wr.
- Undefined: no counter; the queue waits indefinitely.

Decomposition:
- Package sdram_pkg: ADDR_W/DATA_W/MASK_W defaults, state enum (IDLE, ISSUE, WAIT), FIFO entry struct {rd, wr, addr, wdata}.
- Sub-module sdram_sync_fifo: generic DEPTH x entry register FIFO with push/pop/full/empty/count, synchronous reset, reusable by other ports.

Test Plan:
- Single read: push rd addr=0x000123 into an empty queue → core_if.rd=1 two cycles later, held until accept. Core acks after 3 cycles with read_data=0xBEEF → rsp_valid pulse, rsp_rd=1, rsp_rdata=0xBEEF, rsp_err=0.
- Fill: hold accept low and push 5 writes with DEPTH=4 → req_ready=0 after the 4th push. The 5th is not taken until a completion. Writes issue in order with addr/write_data/wr mask 2'b11 stable during ISSUE.
- Error: core asserts error instead of accept → rsp_valid, rsp_err=1, rsp_rdata=0; the next queued request issues normally.
- Accept and ack in the same cycle for a write → single rsp_valid with rsp_rd=0, no WAIT cycle. Request with rd=1, wr=2'b01 → issued as a read with wr=0.
- Reset asserted while in WAIT with 2 entries queued → no rsp, core_if.rd=0 next cycle, req_ready=1, no issue afterward.
- With SDRAM_REQ_TIMEOUT_EN and TIMEOUT=8: accepted but never acked → rsp_err=1 eight cycles after ISSUE entry, and the queue advances.
